// File: rtl/br_stack.sv
// -----------------------------------------------------------------------------
// br_stack - branch checkpoint stack for the rename stage.
//
// Every dispatched branch claims one checkpoint slot that records the
// free-list head pointer and a full map-table snapshot taken after that
// cycle's rename. A correct resolve simply frees the slot. A mispredict
// drives the saved head/map back to the free list and map table in the same
// cycle and kills the slot together with every younger slot.
//
// Each slot also keeps a dependence mask: the set of slots that were live
// (older, unresolved) when it was allocated. A slot is younger than slot k
// exactly when its dep mask has bit k set, so squashing is a single mask test.
//
// Ports
//   clk          in   1                   clock
//   rst          in   1                   synchronous active-high reset
//   push_i       in   1                   branch dispatched this cycle
//   fl_head_i    in   FL_PTR_W+1          free-list head after this dispatch
//   map_i        in   LRF_NUM*PRF_IDX_W   map table after this rename
//   br_state_i   in   `BR_STATE_W         correct / wrong / no resolve
//   br_tag_i     in   BR_NUM              one-hot tag of the resolving branch
//   full_o       out  1                   every slot is in use
//   push_tag_o   out  BR_NUM              one-hot slot granted to a push
//   br_mask_o    out  BR_NUM              live (unresolved) slot mask
//   recover_o    out  1                   mispredict recovery this cycle
//   rc_head_o    out  FL_PTR_W+1          free-list head to restore
//   rc_map_o     out  LRF_NUM*PRF_IDX_W   map snapshot to restore
//
// Handshake: a push is accepted on the rising edge when push_i is high,
// full_o is low and no valid mispredict is being signalled in that cycle.
// A resolve acts only when br_tag_i is one-hot and names a live slot.
// -----------------------------------------------------------------------------

`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module br_stack #(
    parameter int BR_NUM    = 4,
    parameter int FL_PTR_W  = 5,
    parameter int LRF_NUM   = 32,
    parameter int PRF_IDX_W = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [FL_PTR_W:0]              fl_head_i,
    input  logic [LRF_NUM*PRF_IDX_W-1:0]   map_i,
    input  logic [`BR_STATE_W-1:0]         br_state_i,
    input  logic [BR_NUM-1:0]              br_tag_i,
    output logic                           full_o,
    output logic [BR_NUM-1:0]              push_tag_o,
    output logic [BR_NUM-1:0]              br_mask_o,
    output logic                           recover_o,
    output logic [FL_PTR_W:0]              rc_head_o,
    output logic [LRF_NUM*PRF_IDX_W-1:0]   rc_map_o
);

    localparam int MAP_W = LRF_NUM * PRF_IDX_W;
    localparam int IDX_W = (BR_NUM > 1) ? $clog2(BR_NUM) : 1;

    // Slot state
    logic [BR_NUM-1:0] vld_q;
    logic [BR_NUM-1:0] vld_n;
    logic [BR_NUM-1:0] dep_q [BR_NUM];
    logic [BR_NUM-1:0] dep_n [BR_NUM];
    logic [FL_PTR_W:0] head_q [BR_NUM];
    logic [MAP_W-1:0]  map_q [BR_NUM];

    // Resolve decode
    logic              tag_onehot;
    logic              tag_live;
    logic              correct_ok;
    logic              wrong_ok;
    logic [BR_NUM-1:0] correct_clr;

    // Allocation
    logic [BR_NUM-1:0] push_tag;
    logic [IDX_W-1:0]  push_idx;
    logic              push_free;
    logic              push_ok;

    // A resolve is honoured only for a single live tag; anything else is
    // treated as no resolve at all.
    assign tag_onehot = (br_tag_i != '0) &&
                        ((br_tag_i & (br_tag_i - BR_NUM'(1))) == '0);
    assign tag_live   = |(br_tag_i & vld_q);
    assign correct_ok = (br_state_i == `BR_PR_CORRECT) && tag_onehot && tag_live;
    assign wrong_ok   = (br_state_i == `BR_PR_WRONG)   && tag_onehot && tag_live;
    assign correct_clr = correct_ok ? br_tag_i : '0;

`ifdef BS_DEBUG
    // High when a resolve names a tag that is not a single live slot.
    logic bad_resolve;
    assign bad_resolve = ((br_state_i == `BR_PR_CORRECT) || (br_state_i == `BR_PR_WRONG)) &&
                         !(tag_onehot && tag_live);
`endif

    // Lowest-index free slot. Based on the registered valid bits only, so a
    // slot freed by a correct resolve this cycle is not handed out until the
    // next cycle.
    always_comb begin
        push_tag  = '0;
        push_idx  = '0;
        push_free = 1'b0;
        for (int i = 0; i < BR_NUM; i++) begin
            if (!vld_q[i] && !push_free) begin
                push_free   = 1'b1;
                push_tag[i] = 1'b1;
                push_idx    = IDX_W'(i);
            end
        end
    end

    assign full_o     = &vld_q;
    assign push_tag_o = push_tag;
    assign br_mask_o  = vld_q;
    assign recover_o  = wrong_ok;

    // A branch dispatched in the mispredict cycle is on the wrong path.
    assign push_ok = push_i && push_free && !wrong_ok;

    // Recovery mux: one-hot select, zero whenever there is no mispredict.
    always_comb begin
        rc_head_o = '0;
        rc_map_o  = '0;
        if (wrong_ok) begin
            for (int i = 0; i < BR_NUM; i++) begin
                if (br_tag_i[i]) begin
                    rc_head_o = head_q[i];
                    rc_map_o  = map_q[i];
                end
            end
        end
    end

    // Next valid / dependence state.
    always_comb begin
        vld_n = vld_q;
        for (int i = 0; i < BR_NUM; i++) begin
            dep_n[i] = dep_q[i];
        end

        if (correct_ok) begin
            vld_n = vld_n & ~br_tag_i;
            for (int i = 0; i < BR_NUM; i++) begin
                dep_n[i] = dep_n[i] & ~br_tag_i;
            end
        end

        if (wrong_ok) begin
            for (int i = 0; i < BR_NUM; i++) begin
                // The tagged slot itself, plus everything allocated while it was live.
                if (br_tag_i[i] || (|(dep_q[i] & br_tag_i))) begin
                    vld_n[i] = 1'b0;
                end
                dep_n[i] = dep_n[i] & ~br_tag_i;
            end
        end

        // The granted slot is never the one being resolved (that slot is
        // still valid), so the push can be applied after the clears.
        if (push_ok) begin
            vld_n           = vld_n | push_tag;
            dep_n[push_idx] = vld_q & ~correct_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < BR_NUM; i++) begin
                dep_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_n;
            for (int i = 0; i < BR_NUM; i++) begin
                dep_q[i] <= dep_n[i];
            end
        end
    end

    // Checkpoint payload is only read while its slot is valid, so it is not reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            head_q[push_idx] <= fl_head_i;
            map_q[push_idx]  <= map_i;
        end
    end

endmodule

// File: tb/tb_br_stack.sv
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module tb_br_stack;

    localparam int BR_NUM    = 4;
    localparam int FL_PTR_W  = 5;
    localparam int LRF_NUM   = 32;
    localparam int PRF_IDX_W = 6;
    localparam int MAP_W     = LRF_NUM * PRF_IDX_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   push_i;
    logic [FL_PTR_W:0]      fl_head_i;
    logic [MAP_W-1:0]       map_i;
    logic [`BR_STATE_W-1:0] br_state_i;
    logic [BR_NUM-1:0]      br_tag_i;
    logic                   full_o;
    logic [BR_NUM-1:0]      push_tag_o;
    logic [BR_NUM-1:0]      br_mask_o;
    logic                   recover_o;
    logic [FL_PTR_W:0]      rc_head_o;
    logic [MAP_W-1:0]       rc_map_o;

    int checks = 0;
    int errors = 0;

    br_stack #(
        .BR_NUM(BR_NUM), .FL_PTR_W(FL_PTR_W), .LRF_NUM(LRF_NUM), .PRF_IDX_W(PRF_IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .push_i(push_i), .fl_head_i(fl_head_i), .map_i(map_i),
        .br_state_i(br_state_i), .br_tag_i(br_tag_i), .full_o(full_o),
        .push_tag_o(push_tag_o), .br_mask_o(br_mask_o), .recover_o(recover_o),
        .rc_head_o(rc_head_o), .rc_map_o(rc_map_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // exp_q holds the one-hot tags of in-flight branches in program order
    // (oldest first). A mispredict drops its entry and everything after it.
    logic [BR_NUM-1:0] exp_q[$];
    logic [FL_PTR_W:0] m_head [BR_NUM];
    logic [MAP_W-1:0]  m_map [BR_NUM];
    logic [MAP_W-1:0]  fill_map [BR_NUM];

    function automatic logic [BR_NUM-1:0] m_mask();
        logic [BR_NUM-1:0] m = '0;
        foreach (exp_q[i]) m = m | exp_q[i];
        return m;
    endfunction

    function automatic logic [BR_NUM-1:0] m_free_tag();
        logic [BR_NUM-1:0] m = m_mask();
        logic [BR_NUM-1:0] one = 1;
        for (int s = 0; s < BR_NUM; s++) begin
            if (!m[s]) return one << s;
        end
        return '0;
    endfunction

    function automatic int m_idx(logic [BR_NUM-1:0] t);
        for (int s = 0; s < BR_NUM; s++) begin
            if (t[s]) return s;
        end
        return 0;
    endfunction

    function automatic bit m_resolve_ok();
        return ($countones(br_tag_i) == 1) && ((m_mask() & br_tag_i) != '0);
    endfunction

    function automatic logic [MAP_W-1:0] rand_map();
        logic [MAP_W-1:0] m;
        for (int w = 0; w < MAP_W / 32; w++) m[w*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic model_update();
        logic [BR_NUM-1:0] ft = m_free_tag();
        bit ok = m_resolve_ok();
        int p = 0;
        if (rst) begin
            exp_q.delete();
        end else if (br_state_i == `BR_PR_WRONG && ok) begin
            foreach (exp_q[i]) if (exp_q[i] == br_tag_i) p = i;
            while (exp_q.size() > p) void'(exp_q.pop_back());
        end else begin
            if (br_state_i == `BR_PR_CORRECT && ok) begin
                foreach (exp_q[i]) if (exp_q[i] == br_tag_i) p = i;
                exp_q.delete(p);
            end
            if (push_i && ft != '0) begin
                exp_q.push_back(ft);
                m_head[m_idx(ft)] = fl_head_i;
                m_map[m_idx(ft)]  = map_i;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst        = 1'b0;
        push_i     = 1'b0;
        br_state_i = '0;
        br_tag_i   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [FL_PTR_W:0] h, input logic [MAP_W-1:0] m);
        idle();
        push_i    = 1'b1;
        fl_head_i = h;
        map_i     = m;
        step();
        idle();
    endtask

    task automatic fill4();
        for (int k = 0; k < BR_NUM; k++) begin
            fill_map[k] = rand_map();
            push(6'(3 + 2 * k), fill_map[k]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1; push_i = 1'b1; fl_head_i = 6'd9; map_i = rand_map();
        step();
        idle();
        #1;
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_o); end
        checks++; if (br_mask_o !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b want 0000", br_mask_o); end
        checks++; if (recover_o !== 1'b0) begin errors++; $display("FAIL reset_recover got %b want 0", recover_o); end
        checks++; if (push_tag_o !== 4'b0001) begin errors++; $display("FAIL reset_push_tag got %b want 0001", push_tag_o); end
        checks++; if (rc_head_o !== '0) begin errors++; $display("FAIL reset_rc_head got %h want 0", rc_head_o); end
        checks++; if (rc_map_o !== '0) begin errors++; $display("FAIL reset_rc_map got %h want 0", rc_map_o); end
    endtask

    task automatic test_fill();
        logic [BR_NUM-1:0] one = 1;
        do_reset();
        for (int k = 0; k < BR_NUM; k++) begin
            fill_map[k] = rand_map();
            idle();
            push_i = 1'b1; fl_head_i = 6'(3 + 2 * k); map_i = fill_map[k];
            #1;
            checks++; if (push_tag_o !== (one << k)) begin errors++; $display("FAIL fill_tag%0d got %b want %b", k, push_tag_o, one << k); end
            checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL fill_notfull%0d got %b want 0", k, full_o); end
            step();
        end
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b1111) begin errors++; $display("FAIL fill_mask got %b want 1111", br_mask_o); end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_o); end
        checks++; if (push_tag_o !== 4'b0000) begin errors++; $display("FAIL fill_tag_full got %b want 0000", push_tag_o); end
    endtask

    task automatic test_wrong_mid();
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0010;
        #1;
        checks++; if (recover_o !== 1'b1) begin errors++; $display("FAIL wrong_recover got %b want 1", recover_o); end
        checks++; if (rc_head_o !== 6'd5) begin errors++; $display("FAIL wrong_rc_head got %0d want 5", rc_head_o); end
        checks++; if (rc_map_o !== fill_map[1]) begin errors++; $display("FAIL wrong_rc_map got %h want %h", rc_map_o, fill_map[1]); end
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b0001) begin errors++; $display("FAIL wrong_mask got %b want 0001", br_mask_o); end
        checks++; if (push_tag_o !== 4'b0010) begin errors++; $display("FAIL wrong_free_tag got %b want 0010", push_tag_o); end
        checks++; if (recover_o !== 1'b0) begin errors++; $display("FAIL wrong_recover_off got %b want 0", recover_o); end
    endtask

    task automatic test_correct_push();
        do_reset();
        fill4();
        br_state_i = `BR_PR_CORRECT; br_tag_i = 4'b0001; push_i = 1'b1; fl_head_i = 6'd20; map_i = rand_map();
        #1;
        checks++; if (recover_o !== 1'b0) begin errors++; $display("FAIL corr_recover got %b want 0", recover_o); end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL corr_full got %b want 1", full_o); end
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b1110) begin errors++; $display("FAIL corr_mask got %b want 1110", br_mask_o); end
        checks++; if (push_tag_o !== 4'b0001) begin errors++; $display("FAIL corr_free_tag got %b want 0001", push_tag_o); end
        // New youngest branch reuses slot 0; killing it must spare slots 1..3.
        push(6'd21, rand_map());
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0001;
        #1;
        checks++; if (rc_head_o !== 6'd21) begin errors++; $display("FAIL corr_reuse_head got %0d want 21", rc_head_o); end
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b1110) begin errors++; $display("FAIL corr_dep_clear got %b want 1110", br_mask_o); end
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0010;
        #1;
        checks++; if (rc_head_o !== 6'd5) begin errors++; $display("FAIL corr_wrong_head got %0d want 5", rc_head_o); end
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b0000) begin errors++; $display("FAIL corr_wrong_mask got %b want 0000", br_mask_o); end
    endtask

    task automatic test_wrap_map();
        logic [MAP_W-1:0] pat;
        for (int r = 0; r < LRF_NUM; r++) pat[r*PRF_IDX_W +: PRF_IDX_W] = 6'(63 - r);
        do_reset();
        push(6'b100010, pat);
        push(6'd7, rand_map());
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0001;
        #1;
        checks++; if (rc_head_o !== 6'b100010) begin errors++; $display("FAIL wrap_head got %b want 100010", rc_head_o); end
        checks++; if (rc_map_o !== pat) begin errors++; $display("FAIL wrap_map got %h want %h", rc_map_o, pat); end
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b0000) begin errors++; $display("FAIL wrap_mask got %b want 0000", br_mask_o); end
    endtask

    task automatic test_wrong_push();
        do_reset();
        push(6'd11, rand_map());
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0001; push_i = 1'b1; fl_head_i = 6'd12; map_i = rand_map();
        #1;
        checks++; if (recover_o !== 1'b1) begin errors++; $display("FAIL wpush_recover got %b want 1", recover_o); end
        checks++; if (rc_head_o !== 6'd11) begin errors++; $display("FAIL wpush_head got %0d want 11", rc_head_o); end
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b0000) begin errors++; $display("FAIL wpush_mask got %b want 0000", br_mask_o); end
        checks++; if (push_tag_o !== 4'b0001) begin errors++; $display("FAIL wpush_tag got %b want 0001", push_tag_o); end
    endtask

    task automatic test_invalid_resolve();
        do_reset();
        push(6'd1, rand_map());
        push(6'd2, rand_map());
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0011;
        #1;
        checks++; if (recover_o !== 1'b0) begin errors++; $display("FAIL inv_multi_recover got %b want 0", recover_o); end
        checks++; if (rc_head_o !== '0) begin errors++; $display("FAIL inv_multi_head got %0d want 0", rc_head_o); end
        step();
        br_state_i = `BR_PR_WRONG; br_tag_i = 4'b0100;
        #1;
        checks++; if (recover_o !== 1'b0) begin errors++; $display("FAIL inv_dead_recover got %b want 0", recover_o); end
        step();
        br_state_i = `BR_PR_CORRECT; br_tag_i = 4'b1000;
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b0011) begin errors++; $display("FAIL inv_mask got %b want 0011", br_mask_o); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        push(6'd1, rand_map());
        push(6'd2, rand_map());
        push(6'd3, rand_map());
        rst = 1'b1; push_i = 1'b1; fl_head_i = 6'd4; map_i = rand_map();
        step();
        idle();
        #1;
        checks++; if (br_mask_o !== 4'b0000) begin errors++; $display("FAIL rstmid_mask got %b want 0000", br_mask_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b want 0", full_o); end
        checks++; if (recover_o !== 1'b0) begin errors++; $display("FAIL rstmid_recover got %b want 0", recover_o); end
        checks++; if (push_tag_o !== 4'b0001) begin errors++; $display("FAIL rstmid_tag got %b want 0001", push_tag_o); end
    endtask

    task automatic test_random();
        logic [BR_NUM-1:0] exp_mask;
        logic [BR_NUM-1:0] exp_tag;
        logic              exp_rec;
        logic [FL_PTR_W:0] exp_head;
        logic [MAP_W-1:0]  exp_map;
        int sel;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            push_i    = ($urandom_range(0, 1) == 1);
            fl_head_i = 6'($urandom);
            map_i     = rand_map();
            sel = $urandom_range(0, 9);
            if (sel <= 1)      br_state_i = `BR_PR_WRONG;
            else if (sel <= 4) br_state_i = `BR_PR_CORRECT;
            else if (sel == 5) br_state_i = 2'b11;
            else               br_state_i = 2'b00;
            if (exp_q.size() > 0 && $urandom_range(0, 9) < 8)
                br_tag_i = exp_q[$urandom_range(0, exp_q.size() - 1)];
            else
                br_tag_i = 4'($urandom);
            #1;
            exp_mask = m_mask();
            exp_tag  = m_free_tag();
            exp_rec  = (br_state_i == `BR_PR_WRONG) && m_resolve_ok();
            exp_head = exp_rec ? m_head[m_idx(br_tag_i)] : '0;
            exp_map  = exp_rec ? m_map[m_idx(br_tag_i)] : '0;
            checks++; if (br_mask_o !== exp_mask) begin errors++; $display("FAIL rnd_mask c%0d got %b want %b", n, br_mask_o, exp_mask); end
            checks++; if (push_tag_o !== exp_tag) begin errors++; $display("FAIL rnd_tag c%0d got %b want %b", n, push_tag_o, exp_tag); end
            checks++; if (full_o !== (exp_mask == 4'b1111)) begin errors++; $display("FAIL rnd_full c%0d got %b want %b", n, full_o, exp_mask == 4'b1111); end
            checks++; if (recover_o !== exp_rec) begin errors++; $display("FAIL rnd_recover c%0d got %b want %b", n, recover_o, exp_rec); end
            checks++; if (rc_head_o !== exp_head) begin errors++; $display("FAIL rnd_head c%0d got %h want %h", n, rc_head_o, exp_head); end
            checks++; if (rc_map_o !== exp_map) begin errors++; $display("FAIL rnd_map c%0d got %h want %h", n, rc_map_o, exp_map); end
            step();
        end
        idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        idle();
        rst       = 1'b1;
        fl_head_i = '0;
        map_i     = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_wrong_mid();
        test_correct_push();
        test_wrap_map();
        test_wrong_push();
        test_invalid_resolve();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
